des_decryption_unroll4: RTL and testbench
=========================================

// Module: des_decryption_unroll4
// PURPOSE
//  Iterative DES decryptor: 16 Feistel rounds as 4 passes of UNROLL combinational rounds per clock.
//  Consumes the same 768-bit encryption-order round-key bus as the encryptor and applies the keys
//  in reverse (K16..K1). Sits beside the encryptor in the DES datapath.
//  Full round-trip path: encrypt -> decrypt returns the plaintext.
// PARAMETERS
//  UNROLL  4  rounds per clock; legal 1,2,4,8,16; PASSES = 16/UNROLL; CW = max(1,$clog2(PASSES))
// PORTS
//  clk         in   1    clock, all state on posedge
//  rst_n       in   1    asynchronous active-low reset
//  start       in   1    request; sampled only in IDLE, inputs valid same cycle
//  ciphertext  in   64   [1:64] block to decrypt, bit 1 = MSB
//  round_keys  in   768  [1:768] K1..K16 in encryption order, Kn at [(n-1)*48+1 : n*48]
//  busy        out  1    high in ROUND and DONE
//  done        out  1    one-cycle pulse, result valid
//  result      out  64   [1:64] plaintext = IP^-1({R,L}); holds until next accepted start
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, cnt=0, LR=0, key_reg=0, done=0, busy=0.
//  - result = IP^-1(0) while reset is held.
//  FSM states: IDLE, ROUND, DONE.
//  - IDLE: start=1 -> LR<=IP(ciphertext), key_reg<=round_keys, cnt<=0; next ROUND.
//  - ROUND: each cycle LR <= UNROLL rounds applied; key_reg <= key_reg >> (48*UNROLL); cnt++.
//    At cnt==PASSES-1 -> DONE; cnt wraps to 0.
//  - DONE: done=1, busy=1, 1 cycle; next IDLE unconditionally.
//  Key order: stage s (1..UNROLL) of the current pass uses key_reg[769-48*s : 816-48*s].
//  - Pass 0 therefore uses K16, K15, K14, K13; pass 3 ends with K1.
//  Round: L'=R; R'=L ^ f(R,K), where f = P(S(E(R)^K)).
//  - No swap inside the rounds; the swap is done only at the output, as {R,L}.
//  Latency (UNROLL=4): start accepted at edge 0; ROUND for 4 cycles; done=1 in cycle 5.
//  - Earliest next accepted start is the cycle after DONE (IDLE), so the throughput is
//    1 block per 6 cycles.
//  start in ROUND or DONE: ignored, with no effect on LR, key_reg or cnt.
//  ciphertext/round_keys: may change after the accept edge; the block uses only the registered copies.
//  rst_n low mid-operation: immediate abort to reset values; done is never asserted for the aborted block.
//  done and busy are decoded from the registered state and are glitch-free.
// STRUCTURE
//  des_params.vh (shared with the encryptor):
//  - state localparams;
//  - KEY_W=48, BLK_W=64, KEYBUS_W=768;
//  - IP, IP^-1, E, P tables and S-box tables.
//  Sub-module des_round_core: one combinational Feistel round, (L,R,K) -> (L',R').
//  - UNROLL instances are chained by generate.
//  The existing ip_permutation and ip_inverse_permutation blocks are reused for the input and output.
//  Top holds the FSM, counter, LR register and key shift register.
// TESTING (UNROLL=4; round keys from the team's DES key-schedule model)
//  1 key 133457799BBCDFF1, ct 85E813540F0AB405, start 1 cycle
//    -> done exactly 5 cycles after the accept edge; result 0123456789ABCDEF.
//  2 key 0000000000000000, ct 8CA64DE9C1B123A7 -> result 0000000000000000.
//  3 random 1000 key/pt pairs: des_encryption_unroll4 output fed to this block -> result == pt.
//  4 start held high for 20 cycles:
//    -> blocks accepted only in IDLE, one every 6 cycles;
//    -> inputs changed during ROUND do not alter result.
//  5 rst_n pulsed low in cycle 2 of ROUND -> busy=0, done=0 at once.
//    Then a new start with vector 1 -> correct result.
//  6 UNROLL=1 and UNROLL=16 builds, vector 1:
//    -> done at cycle 17 and cycle 2 respectively; result 0123456789ABCDEF.

Source files
------------

// File: rtl/des_decryption_unroll4_pkg.sv
// Package: des_decryption_unroll4_pkg
// Purpose: shared DES constants, FSM state type, permutation/S-box tables and
//          the combinational helpers (IP, IP^-1, Feistel f) used by the decryptor.
// Bit numbering: DES bit n (1 = MSB) of a W-bit value lives at vector index W-n.
package des_decryption_unroll4_pkg;

  localparam int KEY_W    = 48;
  localparam int BLK_W    = 64;
  localparam int HALF_W   = 32;
  localparam int KEYBUS_W = 768;

  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_DONE} state_t;

  localparam int IP_T [64] = '{
    58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
    57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
    61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};

  localparam int IPINV_T [64] = '{
    40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
    38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
    36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
    34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};

  localparam int E_T [48] = '{
    32,1,2,3,4,5,     4,5,6,7,8,9,     8,9,10,11,12,13, 12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};

  localparam int P_T [32] = '{
    16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};

  // Each box is stored as its four 16-entry rows back to back, so the
  // index is simply {row, col} = {b1, b6, b2..b5}.
  localparam int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,   0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,   15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,   3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,   13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,   13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,   1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,   13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,   3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,   14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,   11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,   10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,   4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,   13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,   6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,   1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,   2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [BLK_W-1:0] ip(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] y;
    for (int j = 0; j < BLK_W; j++) y[BLK_W-1-j] = x[BLK_W-IP_T[j]];
    return y;
  endfunction

  function automatic logic [BLK_W-1:0] ip_inv(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] y;
    for (int j = 0; j < BLK_W; j++) y[BLK_W-1-j] = x[BLK_W-IPINV_T[j]];
    return y;
  endfunction

  // f(R,K) = P(S(E(R) ^ K))
  function automatic logic [HALF_W-1:0] feistel_f(input logic [HALF_W-1:0] r,
                                                 input logic [KEY_W-1:0]  k);
    logic [KEY_W-1:0]  e;
    logic [HALF_W-1:0] s;
    logic [HALF_W-1:0] p;
    logic [5:0]        six;
    for (int j = 0; j < KEY_W; j++) e[KEY_W-1-j] = r[HALF_W-E_T[j]];
    e = e ^ k;
    for (int b = 0; b < 8; b++) begin
      six = e[KEY_W-1-6*b -: 6];
      s[HALF_W-1-4*b -: 4] = SBOX[b][{six[5], six[0], six[4:1]}][3:0];
    end
    for (int j = 0; j < HALF_W; j++) p[HALF_W-1-j] = s[HALF_W-P_T[j]];
    return p;
  endfunction

endpackage

// File: rtl/des_decryption_unroll4_round_core.sv
// Module: des_decryption_unroll4_round_core
// Purpose: one combinational DES Feistel round without the half swap.
// Ports:
//   l_in, r_in   in  32  current halves
//   round_key    in  48  subkey for this round
//   l_out, r_out out 32  L' = R, R' = L ^ f(R, K)
module des_decryption_unroll4_round_core
  import des_decryption_unroll4_pkg::*;
(
  input  logic [HALF_W-1:0] l_in,
  input  logic [HALF_W-1:0] r_in,
  input  logic [KEY_W-1:0]  round_key,
  output logic [HALF_W-1:0] l_out,
  output logic [HALF_W-1:0] r_out
);

  assign l_out = r_in;
  assign r_out = l_in ^ feistel_f(r_in, round_key);

endmodule

// File: rtl/des_decryption_unroll4.sv
// Module: des_decryption_unroll4
// Purpose: iterative DES decryptor, 16 rounds as 16/UNROLL passes of UNROLL
//          chained rounds per clock. Keys arrive in encryption order (K1..K16)
//          and are consumed from the K16 end of a shift register.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        request, sampled only in IDLE
//   ciphertext   64-bit block to decrypt (bit 1 = MSB)
//   round_keys   768-bit bus, Kn at DES bits [(n-1)*48+1 : n*48]
//   busy         high in ROUND and DONE
//   done         one-cycle pulse, result valid
//   result       IP^-1({R,L}), held until the next accepted start
module des_decryption_unroll4
  import des_decryption_unroll4_pkg::*;
#(
  parameter int UNROLL = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BLK_W-1:0]    ciphertext,
  input  logic [KEYBUS_W-1:0] round_keys,
  output logic                busy,
  output logic                done,
  output logic [BLK_W-1:0]    result
);

  localparam int PASSES = 16 / UNROLL;
  localparam int CW     = (PASSES > 1) ? $clog2(PASSES) : 1;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [BLK_W-1:0]    lr;
  logic [KEYBUS_W-1:0] key_reg;

  // K16 sits in the lowest 48 bits of the bus, so stage s of a pass takes
  // slice s from the bottom and the register shifts right after each pass.
  for (genvar s = 0; s < UNROLL; s++) begin : g_round
    logic [HALF_W-1:0] l_i, r_i, l_o, r_o;
    if (s == 0) begin : g_first
      assign l_i = lr[BLK_W-1:HALF_W];
      assign r_i = lr[HALF_W-1:0];
    end else begin : g_next
      assign l_i = g_round[s-1].l_o;
      assign r_i = g_round[s-1].r_o;
    end
    des_decryption_unroll4_round_core u_round (
      .l_in      (l_i),
      .r_in      (r_i),
      .round_key (key_reg[KEY_W*s +: KEY_W]),
      .l_out     (l_o),
      .r_out     (r_o)
    );
  end

  // FSM, pass counter, LR register and key shift register.
  // start outside IDLE is ignored entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      lr      <= '0;
      key_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            lr      <= ip(ciphertext);
            key_reg <= round_keys;
            cnt     <= '0;
            state   <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          lr      <= {g_round[UNROLL-1].l_o, g_round[UNROLL-1].r_o};
          key_reg <= key_reg >> (KEY_W * UNROLL);
          if (cnt == CW'(PASSES - 1)) begin
            cnt   <= '0;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE);
  // The final swap happens only here: output is IP^-1({R, L}).
  assign result = ip_inv({lr[HALF_W-1:0], lr[BLK_W-1:HALF_W]});

endmodule

// File: tb/tb_des_decryption_unroll4.sv
// Testbench: tb_des_decryption_unroll4
// Purpose: drives known-answer and random blocks into des_decryption_unroll4.
// A reference DES (key schedule + encryption) produces ciphertexts from random
// plaintexts; a protocol model decides which starts are accepted and when done
// is due, pushing the expected plaintext into a queue that a monitor drains.
module tb_des_decryption_unroll4;

  localparam int UNROLL   = 4;
  localparam int PASSES   = 16 / UNROLL;
  localparam int CLK_HALF = 5;

  localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
  localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] KEY2 = 64'h0000000000000000;
  localparam logic [63:0] CT2  = 64'h8CA64DE9C1B123A7;
  localparam logic [63:0] PT2  = 64'h0000000000000000;

  localparam int IP_TAB [64] = '{
    58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
    57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
    61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int E_TAB [48] = '{
    32,1,2,3,4,5,     4,5,6,7,8,9,     8,9,10,11,12,13, 12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_TAB [32] = '{
    16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
  localparam int PC1_TAB [56] = '{
    57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_TAB [48] = '{
    14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int S_TAB [8][4][16] = '{
    '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
      '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
    '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
      '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
    '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
      '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
    '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
      '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
    '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
      '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
    '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
      '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
    '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
      '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
    '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
      '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [63:0]  ciphertext;
  logic [767:0] round_keys;
  logic         busy;
  logic         done;
  logic [63:0]  result;

  des_decryption_unroll4 #(.UNROLL(UNROLL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ciphertext (ciphertext),
    .round_keys (round_keys),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  always #CLK_HALF clk = ~clk;

  typedef struct {
    logic [63:0] pt;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc       = 0;
  int          next_free = 0;
  int          n_checks  = 0;
  int          n_fail    = 0;
  logic [63:0] cur_exp   = '0;
  logic [63:0] last_pt   = '0;

  // Key schedule: PC1, per-round left rotations of C and D, PC2.
  function automatic logic [767:0] key_schedule(input logic [63:0] key);
    logic [27:0]  c, d;
    logic [55:0]  cd;
    logic [47:0]  k;
    logic [767:0] bus;
    for (int j = 1; j <= 28; j++) begin
      c[28-j] = key[64-PC1_TAB[j-1]];
      d[28-j] = key[64-PC1_TAB[j+27]];
    end
    for (int n = 0; n < 16; n++) begin
      for (int s = 0; s < SHIFTS[n]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int j = 1; j <= 48; j++) k[48-j] = cd[56-PC2_TAB[j-1]];
      bus[767-48*n -: 48] = k;
    end
    return bus;
  endfunction

  function automatic logic [31:0] ref_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] p;
    int          row, col;
    for (int j = 1; j <= 48; j++) x[48-j] = r[32-E_TAB[j-1]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      row = 2 * int'(x[47-6*b]) + int'(x[42-6*b]);
      col = int'(x[46-6*b -: 4]);
      s[31-4*b -: 4] = 4'(S_TAB[b][row][col]);
    end
    for (int j = 1; j <= 32; j++) p[32-j] = s[32-P_TAB[j-1]];
    return p;
  endfunction

  // Forward DES; the final permutation is the inverse of IP built by scattering.
  function automatic logic [63:0] ref_encrypt(input logic [63:0] pt, input logic [767:0] bus);
    logic [63:0] t, pre, out;
    logic [31:0] l, r, nl;
    for (int j = 1; j <= 64; j++) t[64-j] = pt[64-IP_TAB[j-1]];
    l = t[63:32];
    r = t[31:0];
    for (int n = 0; n < 16; n++) begin
      nl = r;
      r  = l ^ ref_f(r, bus[767-48*n -: 48]);
      l  = nl;
    end
    pre = {r, l};
    for (int j = 1; j <= 64; j++) out[64-IP_TAB[j-1]] = pre[64-j];
    return out;
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic apply_stimulus(input logic [63:0] key, input logic [63:0] ct,
                                input logic [63:0] pt, input logic go);
    @(negedge clk);
    ciphertext = ct;
    round_keys = key_schedule(key);
    cur_exp    = pt;
    start      = go;
  endtask

  task automatic random_block(input logic go);
    logic [63:0] key, pt;
    key = {$urandom, $urandom};
    pt  = {$urandom, $urandom};
    apply_stimulus(key, ref_encrypt(pt, key_schedule(key)), pt, go);
  endtask

  task automatic drain();
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4 * PASSES + 20 && exp_q.size() != 0; i++) @(negedge clk);
    check_output("drain_pending", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    check_output("result_hold", result, last_pt);
  endtask

  // Protocol model: a start is taken only when the block is idle, done is due
  // PASSES edges after the accept edge, and the next accept is PASSES+2 later.
  always @(posedge clk) begin
    cyc++;
    if (rst_n && start && cyc >= next_free) begin
      exp_q.push_back(exp_t'{cur_exp, cyc + PASSES});
      next_free = cyc + PASSES + 2;
    end
  end

  // Monitor: busy against the model each cycle, results and latency on done.
  always @(posedge clk) begin
    exp_t e;
    #1;
    check_output("busy", 64'(busy), (cyc + 2 <= next_free) ? 64'd1 : 64'd0);
    if (done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_done: got done=1, expected no pending block (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check_output("result", result, e.pt);
        check_output("latency", 64'(cyc), 64'(e.due));
        last_pt = e.pt;
      end
    end else if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
      e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("[TB] FAIL missing_done: got no done, expected one at cycle %0d (now %0d)", e.due, cyc);
    end
  end

  initial begin
    #(2 * CLK_HALF * 50000);
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    ciphertext = '0;
    round_keys = '0;
    repeat (3) @(negedge clk);
    check_output("reset_busy", 64'(busy), 64'd0);
    check_output("reset_done", 64'(done), 64'd0);
    check_output("reset_result", result, 64'd0);
    rst_n = 1'b1;

    $display("[TB] known-answer vectors");
    apply_stimulus(KEY1, CT1, PT1, 1'b1);
    drain();
    apply_stimulus(KEY2, CT2, PT2, 1'b1);
    drain();

    $display("[TB] start held for 20 cycles with changing inputs");
    for (int i = 0; i < 20; i++) random_block(1'b1);
    drain();

    $display("[TB] reset in the middle of ROUND");
    apply_stimulus(KEY1, CT1, PT1, 1'b1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n     = 1'b0;
    next_free = 0;
    exp_q.delete();
    #1;
    check_output("abort_busy", 64'(busy), 64'd0);
    check_output("abort_done", 64'(done), 64'd0);
    check_output("abort_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(KEY1, CT1, PT1, 1'b1);
    drain();

    $display("[TB] random sparse starts");
    for (int i = 0; i < 600; i++) random_block($urandom_range(0, 3) == 0);
    drain();

    $display("[TB] random back-to-back blocks");
    for (int i = 0; i < 6 * 1000; i++) random_block(1'b1);
    drain();

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
